// File: rtl/inp_pkg.sv
// Shared types and default sizing for the operator input capture path.
package inp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DONE
  } inp_state_t;

  localparam int unsigned INP_WIDTH    = 16;
  localparam int unsigned INP_DB_COUNT = 50000;

endpackage

// File: rtl/debounce.sv
// Push-button synchroniser and debouncer; emits a one-cycle press pulse on a debounced fall.
module debounce
  import inp_pkg::*;
#(
  parameter int unsigned DB_COUNT = INP_DB_COUNT
) (
  input  logic clock,
  input  logic n_reset,
  input  logic btn_n,
  output logic press
);

  localparam int unsigned CntW = $clog2(DB_COUNT + 1);

  logic            btn_meta_q;
  logic            btn_s_q;
  logic            db_q;
  logic            db_d;
  logic            db_dly_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  // Idle level of the active-low button is 1, so the sync chain resets high.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      btn_meta_q <= 1'b1;
      btn_s_q    <= 1'b1;
    end else begin
      btn_meta_q <= btn_n;
      btn_s_q    <= btn_meta_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (btn_s_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(DB_COUNT - 1)) begin
      db_d  = btn_s_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q    <= '0;
      db_q     <= 1'b1;
      db_dly_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      db_q     <= db_d;
      db_dly_q <= db_q;
    end
  end

  // Only the press edge matters; releases are ignored.
  assign press = db_dly_q & ~db_q;

endmodule

// File: rtl/inp_capture.sv
// Captures the synchronised switch word on a debounced button press while a request is armed.
module inp_capture
  import inp_pkg::*;
#(
  parameter int unsigned WIDTH    = INP_WIDTH,
  parameter int unsigned DB_COUNT = INP_DB_COUNT
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_n,
  input  logic             req,
  output logic [WIDTH-1:0] inpval,
  output logic             ack,
  output logic             waiting
);

  logic [WIDTH-1:0] sw_meta_q;
  logic [WIDTH-1:0] sw_s_q;
  logic             press;
  logic             capture;
  inp_state_t       state_q;
  inp_state_t       state_d;
  logic [WIDTH-1:0] inpval_q;
  logic             ack_q;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      sw_meta_q <= '0;
      sw_s_q    <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_s_q    <= sw_meta_q;
    end
  end

  debounce #(
    .DB_COUNT(DB_COUNT)
  ) u_debounce (
    .clock  (clock),
    .n_reset(n_reset),
    .btn_n  (btn_n),
    .press  (press)
  );

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Presses outside ARMED are dropped, so a button already held at arming never captures.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = ARMED;
      ARMED: begin
        if (press) begin
          state_d = DONE;
        end else if (!req) begin
          state_d = IDLE;
        end
      end
      DONE:    if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    waiting = (state_q == ARMED);
    capture = (state_q == ARMED) && press;
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      ack_q    <= 1'b0;
      inpval_q <= '0;
    end else begin
      ack_q <= capture;
      if (capture) begin
        inpval_q <= sw_s_q;
      end
    end
  end

  assign ack    = ack_q;
  assign inpval = inpval_q;

endmodule

// File: tb/tb_inp_capture.sv
// Directed scenarios plus randomized traffic checked each cycle against a behavioural model.
module tb_inp_capture;

  localparam int unsigned W   = 16;
  localparam int unsigned DBC = 4;

  logic         clock = 1'b0;
  logic         n_reset = 1'b1;
  logic [W-1:0] sw = '0;
  logic         btn_n = 1'b1;
  logic         req = 1'b0;
  logic [W-1:0] inpval;
  logic         ack;
  logic         waiting;

  int total = 0;
  int bad = 0;

  inp_capture #(
    .WIDTH   (W),
    .DB_COUNT(DBC)
  ) dut (
    .clock  (clock),
    .n_reset(n_reset),
    .sw     (sw),
    .btn_n  (btn_n),
    .req    (req),
    .inpval (inpval),
    .ack    (ack),
    .waiting(waiting)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: each signal is its input delayed, the button level flips only after
  // DBC consecutive disagreeing synchronised samples, and a capture happens on a fall while armed.
  logic         m_btn_pipe[$];
  logic [W-1:0] m_sw_pipe[$];
  logic         m_dbh[$];
  logic         m_db = 1'b1;
  logic         m_fell = 1'b0;
  int           m_mode = 0;  // 0 idle, 1 armed, 2 done
  logic         m_ack = 1'b0;
  logic [W-1:0] m_inpval = '0;

  initial begin
    logic         bs;
    logic [W-1:0] ss;
    logic         press_now;
    logic         all_diff;
    forever begin
      @(posedge clock or negedge n_reset);
      if (!n_reset) begin
        m_btn_pipe = {1'b1, 1'b1};
        m_sw_pipe  = {W'(0), W'(0)};
        m_dbh      = {};
        m_db       = 1'b1;
        m_fell     = 1'b0;
        m_mode     = 0;
        m_ack      = 1'b0;
        m_inpval   = '0;
      end else begin
        bs = m_btn_pipe.pop_front();
        m_btn_pipe.push_back(btn_n);
        ss = m_sw_pipe.pop_front();
        m_sw_pipe.push_back(sw);
        press_now = m_fell;
        m_fell = 1'b0;
        m_dbh.push_back(bs);
        if (m_dbh.size() > DBC) void'(m_dbh.pop_front());
        if (m_dbh.size() == DBC) begin
          all_diff = 1'b1;
          foreach (m_dbh[i]) if (m_dbh[i] == m_db) all_diff = 1'b0;
          if (all_diff) begin
            m_db   = ~m_db;
            m_fell = (m_db == 1'b0);
            m_dbh  = {};
          end
        end
        m_ack = 1'b0;
        case (m_mode)
          0: if (req) m_mode = 1;
          1: begin
            if (press_now) begin
              m_ack    = 1'b1;
              m_inpval = ss;
              m_mode   = 2;
            end else if (!req) begin
              m_mode = 0;
            end
          end
          default: if (!req) m_mode = 0;
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (n_reset) begin
        check("model_ack", 32'(ack), 32'(m_ack));
        check("model_waiting", 32'(waiting), 32'(m_mode == 1));
        check("model_inpval", 32'(inpval), 32'(m_inpval));
      end
    end
  end

  task automatic cyc(input int n, output int acks);
    acks = 0;
    repeat (n) begin
      @(negedge clock);
      if (ack) acks++;
    end
  endtask

  // Drives a press held for `hold` cycles and reports the cycle the ack appeared (0 if none).
  task automatic press_wait(input int hold, input int window, output int lat, output int acks);
    lat  = 0;
    acks = 0;
    btn_n = 1'b0;
    for (int i = 1; i <= window; i++) begin
      @(negedge clock);
      if (ack) begin
        acks++;
        if (lat == 0) lat = i;
      end
      if (i == hold) btn_n = 1'b1;
    end
  endtask

  initial begin
    int a;
    int lat;
    #1 n_reset = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_waiting", 32'(waiting), 32'd0);
    check("reset_inpval", 32'(inpval), 32'd0);
    n_reset = 1'b1;
    cyc(2, a);

    // 1: basic capture
    sw  = 16'hA5C3;
    req = 1'b1;
    cyc(1, a);
    check("s1_waiting_up", 32'(waiting), 32'd1);
    cyc(3, a);
    press_wait(10, 7, lat, a);
    check("s1_ack_latency", 32'(lat), 32'd7);
    check("s1_inpval", 32'(inpval), 32'hA5C3);
    check("s1_waiting_down", 32'(waiting), 32'd0);
    cyc(10, a);
    check("s1_single_ack", 32'(a), 32'd0);
    req = 1'b0;
    cyc(2, a);
    check("s1_idle_waiting", 32'(waiting), 32'd0);

    // 2: bounce rejection then clean press
    req = 1'b1;
    cyc(2, a);
    for (int r = 0; r < 5; r++) begin
      int b;
      btn_n = 1'b0;
      cyc(3, b);
      a += b;
      btn_n = 1'b1;
      cyc(2, b);
      a += b;
    end
    cyc(6, lat);
    check("s2_bounce_no_ack", 32'(a + lat), 32'd0);
    check("s2_inpval_kept", 32'(inpval), 32'hA5C3);
    sw = 16'h5A5A;
    cyc(3, a);
    press_wait(6, 14, lat, a);
    check("s2_clean_one_ack", 32'(a), 32'd1);
    check("s2_inpval", 32'(inpval), 32'h5A5A);
    req = 1'b0;
    cyc(3, a);

    // 3: held before arm
    btn_n = 1'b0;
    cyc(10, a);
    req = 1'b1;
    cyc(8, a);
    check("s3_held_no_ack", 32'(a), 32'd0);
    check("s3_waiting", 32'(waiting), 32'd1);
    btn_n = 1'b1;
    sw    = 16'h0042;
    cyc(8, a);
    press_wait(6, 12, lat, a);
    check("s3_one_ack", 32'(a), 32'd1);
    check("s3_inpval", 32'(inpval), 32'h0042);
    req = 1'b0;
    cyc(3, a);

    // 4: request withdrawn, press in idle forgotten
    req = 1'b1;
    cyc(3, a);
    req = 1'b0;
    cyc(1, a);
    check("s4_waiting_drop", 32'(waiting), 32'd0);
    press_wait(8, 16, lat, a);
    req = 1'b1;
    cyc(10, lat);
    check("s4_no_ack", 32'(a + lat), 32'd0);
    req = 1'b0;
    cyc(3, a);

    // 5: second press in DONE ignored
    sw  = 16'h1111;
    req = 1'b1;
    cyc(3, a);
    press_wait(8, 16, lat, a);
    check("s5_first_ack", 32'(a), 32'd1);
    sw = 16'h2222;
    press_wait(10, 20, lat, a);
    check("s5_no_second_ack", 32'(a), 32'd0);
    check("s5_inpval_kept", 32'(inpval), 32'h1111);
    req = 1'b0;
    cyc(3, a);

    // 6: asynchronous reset mid-debounce
    req = 1'b1;
    cyc(2, a);
    btn_n = 1'b0;
    cyc(4, a);
    #2 n_reset = 1'b0;
    #1;
    check("s6_async_ack", 32'(ack), 32'd0);
    check("s6_async_waiting", 32'(waiting), 32'd0);
    check("s6_async_inpval", 32'(inpval), 32'd0);
    @(negedge clock);
    btn_n   = 1'b1;
    n_reset = 1'b1;
    #1 check("s6_waiting_after_release", 32'(waiting), 32'd0);
    cyc(1, a);
    check("s6_rearmed", 32'(waiting), 32'd1);
    req = 1'b0;
    cyc(3, a);

    // Randomized traffic
    begin
      int btn_left = 3;
      for (int c = 0; c < 4000; c++) begin
        @(negedge clock);
        if (btn_left == 0) begin
          btn_n    = ~btn_n;
          btn_left = $urandom_range(0, 3) == 0 ? $urandom_range(6, 20) : $urandom_range(1, 5);
        end else begin
          btn_left--;
        end
        if ($urandom_range(0, 24) == 0) req = ~req;
        if ($urandom_range(0, 7) == 0) sw = W'($urandom);
        if ($urandom_range(0, 999) == 0) begin
          #2 n_reset = 1'b0;
          @(negedge clock);
          n_reset = 1'b1;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/inp_capture.md
# inp_capture

Input-side capture unit between the board's raw switches/push-button and the processor's `inpval` input path. It synchronises the 16 switch lines and debounces an active-low "enter" button. On a processor request it latches the switch word on the next clean button press and returns a one-cycle acknowledge. It is the receive-side counterpart of the `out` display block: `out` carries processor values out to the LEDs, and this block carries operator values in.

## Interface
Parameters:
- `WIDTH`, 16, switch/data word width.
- `DB_COUNT`, 50000, consecutive stable cycles required to accept a button level change (1 ms at 50 MHz); legal range ≥ 1.

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `n_reset`  in  1  asynchronous, active-low reset.
- `sw`  in  WIDTH  raw switch lines, asynchronous to `clock`.
- `btn_n`  in  1  raw push-button, active-low (0 = pressed), asynchronous, bouncing.
- `req`  in  1  processor input request, level; held high until `ack` is seen.
- `inpval`  out  WIDTH  last captured switch word; stable between captures.
- `ack`  out  1  one-cycle pulse; `inpval` is valid in the same cycle.
- `waiting`  out  1  high while a request is armed and no press has been taken yet (operator prompt LED).

## Operation
- Synchroniser: two flops on every `sw` bit and on `btn_n`. Reset values: `sw` path 0, `btn_n` path 1. Output names: `sw_s`, `btn_s`.
- Debounce: debounced level `db` resets to 1. Counter `cnt` has width clog2(DB_COUNT+1) and resets to 0.
  - `btn_s == db`: `cnt <= 0`.
  - Else, if `cnt == DB_COUNT-1`: `db <= btn_s`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - A glitch shorter than DB_COUNT cycles never changes `db`.
- Press event: `db_q` (registered `db`, reset 1) equals 1 while `db` equals 0. Release events are ignored.
- FSM states: IDLE, ARMED, DONE. Reset state is IDLE.
  - IDLE: when `req`=1, go to ARMED. Presses in IDLE are discarded, not buffered.
  - ARMED: `waiting`=1. On a press event: `inpval <= sw_s`, `ack <= 1`, go to DONE. If `req` drops without a press, return to IDLE with no ack.
  - DONE: `ack` is 0. Stay until `req`=0, then go to IDLE. A new press in DONE is discarded.
- A press event in the same cycle that IDLE goes to ARMED is discarded. Arming never captures a button that was already pressed before the request. The operator must release and press again.
- Reset at any time: state goes to IDLE; `ack`=0, `waiting`=0, `inpval`=0, `db`=1, `cnt`=0. Any capture in progress is lost.

## Timing
- Reset values of outputs: `inpval`=0, `ack`=0, `waiting`=0.
- `btn_n` falls and stays low before edge k:
  - `btn_s`=0 after edge k+1.
  - `db`=0 after edge k+1+DB_COUNT.
  - `ack`=1 after edge k+2+DB_COUNT, for exactly one cycle, provided the state is ARMED.
- `inpval` holds the `sw_s` value sampled at the ack edge. Switch changes must be stable for ≥ 2 cycles before that edge to be captured.
- `waiting` is registered from the state: 1 in the cycle after the IDLE→ARMED edge, 0 in the same cycle `ack` rises.
- `req` high to ARMED takes 1 cycle. DONE to IDLE takes 1 cycle after `req` low. The minimum request-to-request spacing is 2 cycles.

## Structure
- Package `inp_pkg`:
  - Enum `inp_state_t` {IDLE, ARMED, DONE}.
  - Default constants `INP_WIDTH`=16 and `INP_DB_COUNT`=50000.
- One sub-module, `debounce` (parameter DB_COUNT). It contains the 2-flop synchroniser, the counter and `db`/`db_q`, and outputs a registered `press` pulse. `inp_capture` instantiates it once and keeps the `sw` synchroniser and FSM locally.

## Test plan
All scenarios use DB_COUNT=4.
1. Basic capture: `sw`=16'hA5C3, `req`=1, then `btn_n` held low 10 cycles → `waiting` goes 1. Exactly one `ack` pulse 2+4+1 cycles after the `btn_n` fall, `inpval`=16'hA5C3, `waiting`=0. Drop `req` → state IDLE next cycle.
2. Bounce rejection: in ARMED, `btn_n` pulses low for 3 cycles, repeated 5 times with 2-cycle highs between → no `ack`, `inpval` unchanged. A following clean 6-cycle low → one `ack`.
3. Held-before-arm: `btn_n` low and debounced, then `req`=1 → no `ack` while held. Release for 6 cycles, press again, `sw`=16'h0042 → `ack`, `inpval`=16'h0042.
4. Request withdrawn: `req`=1 for 3 cycles, then 0, then a press → no `ack`, `waiting` returns to 0. The press in IDLE is not remembered by a later `req`.
5. Double press in DONE: after the ack with `sw`=16'h1111, keep `req`=1, change `sw` to 16'h2222 and press again → no second `ack`, `inpval` stays 16'h1111.
6. Reset mid-debounce: in ARMED with `cnt`=2, assert `n_reset` for 1 cycle → all outputs 0 immediately (asynchronous). After release, `waiting`=0 until `req` is re-observed.
